// File: rtl/riscv_mmio_pkg.sv
// Shared types and constants for the RISC-V MMIO channel controller.
package riscv_mmio_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } mmio_state_e;

  // Register offsets inside one channel slot.
  localparam logic [2:0] TX_OFF = 3'd0;
  localparam logic [2:0] RX_OFF = 3'd4;

  // funct3 access-size codes that the window accepts.
  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_LW = 3'b010;

  // Bytes occupied by each channel.
  localparam int unsigned CH_STRIDE = 8;

  // Width of a channel index; a single channel still needs one bit.
  function automatic int unsigned ch_idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/riscv_mmio_addr_decode.sv
// Combinational window decode: claims in-window accesses and classifies them.
module riscv_mmio_addr_decode
  import riscv_mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0400,
  parameter int unsigned NUM_CH    = 2,
  parameter int unsigned CH_W      = 1
) (
  input  logic [31:0]     addr,
  input  logic            mem_valid,
  input  logic            mem_write,
  input  logic [2:0]      funct3,
  output logic            hit,
  output logic            legal,
  output logic [CH_W-1:0] ch,
  output logic            is_rx
);

  localparam logic [31:0] WIN_BYTES = 32'(CH_STRIDE * NUM_CH);

  logic [31:0] offset;
  logic [2:0]  reg_off;
  logic        in_win;
  logic        aligned;
  logic        is_tx;

  // Window compare, channel index and access legality (SB to TX, LW to RX only).
  always_comb begin
    offset  = addr - BASE_ADDR;
    // addr >= BASE_ADDR guarantees the subtraction did not wrap.
    in_win  = (addr >= BASE_ADDR) && (offset < WIN_BYTES);
    hit     = mem_valid && in_win;
    reg_off = {addr[2], 2'b00};
    aligned = (addr[1:0] == 2'b00);
    is_rx   = (reg_off == RX_OFF);
    is_tx   = (reg_off == TX_OFF);
    ch      = CH_W'(offset >> $clog2(CH_STRIDE));
    legal   = hit && aligned &&
              ((is_tx && mem_write && (funct3 == F3_SB)) ||
               (is_rx && !mem_write && (funct3 == F3_LW)));
  end

endmodule

// File: rtl/riscv_mmio_controller.sv
// MMIO channel controller: stalls the core across a req/ack handshake with
// a per-access timeout, and returns load data through the write-back mux.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no transaction; a legal hit stalls and latches the request
// WAIT  | ch_req held; waiting on the selected channel's ack or timeout
// DONE  | stall released, load data/err presented, core commits
module riscv_mmio_controller
  import riscv_mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0400,
  parameter int unsigned NUM_CH    = 2,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   mem_valid,
  input  logic                   mem_write,
  input  logic [2:0]             funct3,
  input  logic [31:0]            addr,
  input  logic [31:0]            wdata,
  output logic                   mmio_hit,
  output logic                   stall,
  output logic [31:0]            rdata,
  output logic                   rdata_valid,
  output logic                   err,
  output logic [NUM_CH-1:0]      ch_req,
  output logic                   ch_we,
  output logic [7:0]             ch_wdata,
  input  logic [NUM_CH-1:0]      ch_ack,
  input  logic [32*NUM_CH-1:0]   ch_rdata
);

  localparam int unsigned CH_W  = ch_idx_width(NUM_CH);
  localparam int unsigned CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  mmio_state_e       state_q, state_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic              we_q, we_d;
  logic [7:0]        wdata_q, wdata_d;
  logic [NUM_CH-1:0] req_q, req_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              to_q, to_d;

  logic              dec_hit;
  logic              dec_legal;
  logic [CH_W-1:0]   dec_ch;
  logic              dec_is_rx;

  logic              ack_sel;
  logic [31:0]       sel_rdata;
  logic              stall_c;
  logic              err_c;
  logic              rv_c;
  logic [31:0]       rdata_c;

  // Only the TX byte travels to the peripheral.
  logic              unused_wdata_hi;
  assign unused_wdata_hi = ^wdata[31:8];

  riscv_mmio_addr_decode #(
    .BASE_ADDR (BASE_ADDR),
    .NUM_CH    (NUM_CH),
    .CH_W      (CH_W)
  ) u_decode (
    .addr      (addr),
    .mem_valid (mem_valid),
    .mem_write (mem_write),
    .funct3    (funct3),
    .hit       (dec_hit),
    .legal     (dec_legal),
    .ch        (dec_ch),
    .is_rx     (dec_is_rx)
  );

  // Ack of the requested channel only; req_q is one-hot and zero outside WAIT.
  assign ack_sel = |(ch_ack & req_q);

  // Read-data mux for the latched channel.
  always_comb begin
    sel_rdata = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (ch_q == CH_W'(c)) sel_rdata = ch_rdata[32*c +: 32];
    end
  end

  // Next-state and output logic for the handshake FSM.
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    req_d   = req_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    to_d    = to_q;
    stall_c = 1'b0;
    err_c   = 1'b0;
    rv_c    = 1'b0;
    rdata_c = '0;
    unique case (state_q)
      IDLE: begin
        if (dec_legal) begin
          stall_c = 1'b1;
          ch_d    = dec_ch;
          we_d    = ~dec_is_rx;
          wdata_d = wdata[7:0];
          req_d   = NUM_CH'(1) << dec_ch;
          cnt_d   = '0;
          rdata_d = '0;
          to_d    = 1'b0;
          state_d = WAIT;
        end else if (dec_hit) begin
          // Illegal in-window access: answered at once, no peripheral traffic.
          err_c = 1'b1;
          rv_c  = ~mem_write;
        end
      end
      WAIT: begin
        stall_c = 1'b1;
        if (ack_sel) begin
          // Ack beats a coincident timeout.
          if (!we_q) rdata_d = sel_rdata;
          req_d   = '0;
          state_d = DONE;
        end else if (cnt_q == CNT_LAST) begin
          rdata_d = '0;
          to_d    = 1'b1;
          req_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        // Always back to IDLE so the committing instruction cannot retrigger.
        rv_c    = ~we_q;
        rdata_c = we_q ? 32'd0 : rdata_q;
        err_c   = to_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, latched request and counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ch_q    <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      req_q   <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      req_q   <= req_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      to_q    <= to_d;
    end
  end

  // Combinational outputs are forced quiet while reset is held, so a reset
  // in the middle of a transaction releases the core immediately.
  assign mmio_hit    = dec_hit & ~reset;
  assign stall       = stall_c & ~reset;
  assign err         = err_c & ~reset;
  assign rdata_valid = rv_c & ~reset;
  assign rdata       = reset ? 32'd0 : rdata_c;
  assign ch_req      = req_q;
  assign ch_we       = (state_q == WAIT) & we_q;
  assign ch_wdata    = ((state_q == WAIT) && we_q) ? wdata_q : 8'd0;

endmodule
